fwd_hazard_ctrl: RTL and testbench

- Generates the 2-bit `slct` codes for the two EX-stage 4:1 operand muxes (ALU operand A and B).
- Tracks destination-register state for the two instructions ahead of the one in ID.
- Detects load-use hazards, requests a one-cycle ID stall, and injects a bubble into EX.
- Sits between the ID/EX pipeline boundary and the operand muxes. Its select outputs are registered, so they become valid in the same cycle the instruction enters EX.

---
 rtl/fwd_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding select generation and load-use hazard control.
// Tracks the destination of the instructions in EX and MEM and registers the mux selects.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_imm_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_slct,
  output logic [1:0]        fwd_b_slct,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_IMM   = 2'b11;

  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwrite;
  logic              r_ex_memread;
  logic              r_mem_valid;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_regwrite;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic       w_stall, w_accept;
  logic [1:0] w_a_nxt, w_b_nxt;

  // $0 is hardwired to zero, so a write to it never produces a forwardable value.
  function automatic logic slot_match(input logic v, input logic wr,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
    return v & wr & (rd == r) & (r != {REG_AW{1'b0}});
  endfunction

  assign w_ex_rs  = slot_match(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  id_rs);
  assign w_ex_rt  = slot_match(r_ex_valid,  r_ex_regwrite,  r_ex_rd,  id_rt);
  assign w_mem_rs = slot_match(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rs);
  assign w_mem_rt = slot_match(r_mem_valid, r_mem_regwrite, r_mem_rd, id_rt);

  assign w_stall  = ~rst & id_valid & ~flush & r_ex_memread &
                    ((id_use_rs & w_ex_rs) | (id_use_rt & w_ex_rt));
  assign w_accept = id_valid & ~flush & ~w_stall;

  // Next-cycle operand selects; the younger EX producer takes priority over MEM.
  always_comb begin
    w_a_nxt = SEL_RF;
    w_b_nxt = SEL_RF;
    if (id_use_rs & w_ex_rs) begin
      w_a_nxt = SEL_EXMEM;
    end else if (id_use_rs & w_mem_rs) begin
      w_a_nxt = SEL_MEMWB;
    end else begin
      w_a_nxt = SEL_RF;
    end
    if (id_imm_b) begin
      w_b_nxt = SEL_IMM;
    end else if (id_use_rt & w_ex_rt) begin
      w_b_nxt = SEL_EXMEM;
    end else if (id_use_rt & w_mem_rt) begin
      w_b_nxt = SEL_MEMWB;
    end else begin
      w_b_nxt = SEL_RF;
    end
  end

  // Pipeline slot tracking and registered selects; a rejected ID cycle becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= {REG_AW{1'b0}};
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= {REG_AW{1'b0}};
      r_mem_regwrite <= 1'b0;
      r_fwd_a        <= SEL_RF;
      r_fwd_b        <= SEL_RF;
    end else begin
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= id_rd;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
        r_fwd_a       <= w_a_nxt;
        r_fwd_b       <= w_b_nxt;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= {REG_AW{1'b0}};
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
        r_fwd_a       <= SEL_RF;
        r_fwd_b       <= SEL_RF;
      end
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall      = w_stall;
  assign fwd_a_slct = r_fwd_a;
  assign fwd_b_slct = r_fwd_b;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench: a pipeline-history model checked every cycle, plus directed literal checks.
module tb_fwd_hazard_ctrl;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rs, id_use_rt, id_imm_b, id_regwrite, id_memread, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic stall;
  logic [1:0] fwd_a_slct, fwd_b_slct;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_err = 0;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_imm_b(id_imm_b), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .stall(stall),
    .fwd_a_slct(fwd_a_slct), .fwd_b_slct(fwd_b_slct), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: in-flight instructions, index 0 = one stage ahead of ID (EX), 1 = two ahead (MEM).
  logic       m_valid [2];
  logic [4:0] m_rd    [2];
  logic       m_wr    [2];
  logic       m_ld    [2];
  logic [1:0] m_a, m_b;
  logic [CW-1:0] m_cnt;

  // Age of the youngest in-flight instruction that will write r, -1 if none.
  function automatic int newest(input logic [4:0] r);
    for (int s = 0; s < 2; s++)
      if (m_valid[s] && m_wr[s] && r != 5'd0 && m_rd[s] == r) return s;
    return -1;
  endfunction

  function automatic logic [1:0] sel_for(input logic used, input logic [4:0] r);
    int age;
    age = newest(r);
    if (!used) return 2'b00;
    if (age == 0) return 2'b01;
    if (age == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    return !rst && id_valid && !flush && m_valid[0] && m_ld[0] &&
           ((id_use_rs && newest(id_rs) == 0) || (id_use_rt && newest(id_rt) == 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        m_valid[s] <= 1'b0; m_rd[s] <= 5'd0; m_wr[s] <= 1'b0; m_ld[s] <= 1'b0;
      end
      m_a <= 2'b00; m_b <= 2'b00; m_cnt <= '0;
    end else begin
      m_valid[1] <= m_valid[0]; m_rd[1] <= m_rd[0]; m_wr[1] <= m_wr[0]; m_ld[1] <= m_ld[0];
      if (id_valid && !flush && !exp_stall()) begin
        m_valid[0] <= 1'b1; m_rd[0] <= id_rd; m_wr[0] <= id_regwrite; m_ld[0] <= id_memread;
        m_a <= sel_for(id_use_rs, id_rs);
        m_b <= id_imm_b ? 2'b11 : sel_for(id_use_rt, id_rt);
      end else begin
        m_valid[0] <= 1'b0; m_rd[0] <= 5'd0; m_wr[0] <= 1'b0; m_ld[0] <= 1'b0;
        m_a <= 2'b00; m_b <= 2'b00;
      end
      if (exp_stall() && m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 1'b1;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    check("cyc_stall", {15'd0, stall}, {15'd0, exp_stall()});
    check("cyc_fwd_a", {14'd0, fwd_a_slct}, {14'd0, m_a});
    check("cyc_fwd_b", {14'd0, fwd_b_slct}, {14'd0, m_b});
    check("cyc_cnt", {14'd0, stall_cnt}, {14'd0, m_cnt});
  end

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic imm,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_imm_b = imm; id_rd = rd; id_regwrite = rw; id_memread = mr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // lw $8 followed by add $9,$8,$8: one stall cycle, then the add enters EX.
  task automatic loaduse();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); tick();
    tick();
    nop(2);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_a", {14'd0, fwd_a_slct}, 16'd0);
    check("rst_b", {14'd0, fwd_b_slct}, 16'd0);
    check("rst_cnt", {14'd0, stall_cnt}, 16'd0);
    check("rst_stall", {15'd0, stall}, 16'd0);
    rst = 1'b0;
    nop(1);

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); #1;
    check("exfwd_stall", {15'd0, stall}, 16'd0);
    tick();
    check("exfwd_a", {14'd0, fwd_a_slct}, 16'd1);
    check("exfwd_b", {14'd0, fwd_b_slct}, 16'd0);
    nop(2);

    // add $3 ; nop ; or $6,$7,$3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
    nop(1);
    drive(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check("memfwd_a", {14'd0, fwd_a_slct}, 16'd0);
    check("memfwd_b", {14'd0, fwd_b_slct}, 16'd2);
    nop(2);

    // add $0 ; nop ; or $6,$7,$0 -> no forwarding from $0
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    nop(1);
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check("zero_b", {14'd0, fwd_b_slct}, 16'd0);
    nop(2);

    // lw $8 ; add $9,$8,$8
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #1;
    check("lu_stall1", {15'd0, stall}, 16'd1);
    tick();
    check("lu_bub_a", {14'd0, fwd_a_slct}, 16'd0);
    check("lu_bub_b", {14'd0, fwd_b_slct}, 16'd0);
    check("lu_cnt1", {14'd0, stall_cnt}, 16'd1);
    check("lu_stall2", {15'd0, stall}, 16'd0);
    tick();
    check("lu_a", {14'd0, fwd_a_slct}, 16'd2);
    check("lu_b", {14'd0, fwd_b_slct}, 16'd2);
    check("lu_cnt2", {14'd0, stall_cnt}, 16'd1);
    nop(2);

    // add $5 ; add $5 ; sub $6,$5,$5 -> newest wins
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    check("dup_a", {14'd0, fwd_a_slct}, 16'd1);
    check("dup_b", {14'd0, fwd_b_slct}, 16'd1);
    nop(2);

    // add $5 ; addi $7,$5,4
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    check("imm_a", {14'd0, fwd_a_slct}, 16'd1);
    check("imm_b", {14'd0, fwd_b_slct}, 16'd3);
    nop(2);

    // lw $8 ; dependent add with flush -> flush wins
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1); #1;
    check("fl_stall", {15'd0, stall}, 16'd0);
    tick();
    check("fl_cnt", {14'd0, stall_cnt}, 16'd1);
    check("fl_a", {14'd0, fwd_a_slct}, 16'd0);
    check("fl_b", {14'd0, fwd_b_slct}, 16'd0);
    nop(2);

    // Bring the 2-bit counter to 3, then reset asynchronously mid-stall.
    loaduse(); loaduse();
    check("sat_pre", {14'd0, stall_cnt}, 16'd3);
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); tick();
    check("ar_lw_a", {14'd0, fwd_a_slct}, 16'd1);
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); #1;
    check("ar_stall_pre", {15'd0, stall}, 16'd1);
    #1 rst = 1'b1;
    #1;
    check("ar_stall", {15'd0, stall}, 16'd0);
    check("ar_a", {14'd0, fwd_a_slct}, 16'd0);
    check("ar_cnt", {14'd0, stall_cnt}, 16'd0);
    nop(2);
    rst = 1'b0;
    nop(1);
    loaduse();
    check("post_cnt1", {14'd0, stall_cnt}, 16'd1);
    loaduse(); loaduse(); loaduse();
    check("post_sat", {14'd0, stall_cnt}, 16'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
